// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared constants, state type and helpers for the display scanner
package display_scan_ctrl_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int VALUE_W  = DIGITS * NIBBLE_W;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Prescaler counter width for a given refresh period; never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // A digit is dark when blanking is on, it is not digit 0, and it and every more
  // significant nibble of the frame snapshot are zero.
  function automatic logic digit_blanked(input logic [VALUE_W-1:0] shadow,
                                         input logic [1:0]         idx,
                                         input logic               blank_lz);
    logic [DIGITS-1:0] nz;
    for (int k = 0; k < DIGITS; k++) begin
      nz[k] = |shadow[k*NIBBLE_W +: NIBBLE_W];
    end
    return blank_lz && (idx != 2'd0) && ((nz >> idx) == '0);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_refresh_div.sv
// rtl/display_scan_ctrl_refresh_div.sv - per-digit refresh prescaler with clear
module refresh_div
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int           W    = presc_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  // Count 0..DIV-1 and wrap; clear holds the count at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 4-digit display scan sequencer with leading-zero blanking
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [VALUE_W-1:0] value,
  input  logic               blank_lz,
  output logic [DIGITS-1:0]  sel,
  output logic [DIGITS-1:0]  an,
  output logic [1:0]         digit_idx,
  output logic               frame_tick
);

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [DIGITS-1:0]  r_sel;
  logic [DIGITS-1:0]  r_an;
  logic               r_tick;
  logic [VALUE_W-1:0] r_shadow;

  state_t             w_state_nxt;
  logic [1:0]         w_idx_nxt;
  logic [DIGITS-1:0]  w_sel_nxt;
  logic [DIGITS-1:0]  w_an_nxt;
  logic               w_tick_nxt;
  logic [VALUE_W-1:0] w_shadow_nxt;
  logic               w_clr;
  logic               w_presc_tick;

  refresh_div #(
    .DIV (DIV)
  ) u_refresh_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_presc_tick)
  );

  // Next-state and next-output decode; outputs are computed from the next state so
  // that the registered values line up with the digit actually being dwelt on.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_tick_nxt   = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr     = 1'b1;
        w_idx_nxt = 2'd0;
        if (en) begin
          w_state_nxt  = SCAN;
          w_shadow_nxt = value;
        end
      end
      SCAN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
          w_idx_nxt   = 2'd0;
        end else if (w_presc_tick) begin
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            // Frame boundary: snapshot the new value so a frame is never torn.
            w_shadow_nxt = value;
            w_tick_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
    w_sel_nxt = DIGITS'(1) << w_idx_nxt;
    if (w_state_nxt == SCAN && !digit_blanked(w_shadow_nxt, w_idx_nxt, blank_lz)) begin
      w_an_nxt = ~w_sel_nxt;
    end else begin
      w_an_nxt = '1;
    end
  end

  // State and output registers; reset overrides everything including enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_sel    <= DIGITS'(1);
      r_an     <= '1;
      r_tick   <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_sel    <= w_sel_nxt;
      r_an     <= w_an_nxt;
      r_tick   <= w_tick_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  assign sel        = r_sel;
  assign an         = r_an;
  assign digit_idx  = r_idx;
  assign frame_tick = r_tick;

endmodule
